// File: rtl/tl_vc_arbiter_pkg.sv
// Shared transaction-layer definitions: FSM encoding, VC count, default widths
// and the destination-field helper used by the arbiter, FIFO and demux blocks.
package tl_pkg;

   localparam int NUM_VC      = 4;
   localparam int TL_DATA_W   = 12;
   localparam int TL_ADDR_W   = 3;
   localparam int TL_DEST_LSB = 8;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } tl_state_e;

   function automatic logic [1:0] dest_field(input logic [TL_DATA_W-1:0] word,
                                             input int lsb);
      logic [TL_DATA_W-1:0] sh;
      sh = word >> lsb;
      return sh[1:0];
   endfunction

endpackage

// File: rtl/tl_vc_arbiter_rr_pick.sv
// Combinational 4-way picker. Round-robin from ptr by default; lowest index
// wins when TL_ARB_STRICT_PRIO_EN is defined (ptr is then ignored).
module tl_rr_pick
   import tl_pkg::*;
(
   input  logic [NUM_VC-1:0] eligible,
   input  logic [1:0]        ptr,
   output logic [NUM_VC-1:0] grant,
   output logic [1:0]        grant_idx
);

`ifdef TL_ARB_STRICT_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int k = NUM_VC-1; k >= 0; k--) begin
         if (eligible[k]) begin
            grant     = '0;
            grant[k]  = 1'b1;
            grant_idx = 2'(k);
         end
      end
   end
`else
   logic [1:0] idx;

   // Scan farthest-first so the candidate closest to ptr is written last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = '0;
      for (int k = NUM_VC-1; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (eligible[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end
`endif

endmodule

// File: rtl/tl_vc_arbiter.sv
// Transaction-layer control: RESET/INIT/IDLE/ACTIVE/ERROR sequencing, threshold
// latch and VC-to-destination arbitration. Define TL_ARB_STRICT_PRIO_EN for strict priority.
module tl_vc_arbiter
   import tl_pkg::*;
#(
   parameter int DATA_W   = TL_DATA_W,
   parameter int ADDR_W   = TL_ADDR_W,
   parameter int DEST_LSB = TL_DEST_LSB
)
(
   input  logic                     clk,
   input  logic                     reset_L,
   input  logic                     init,
   input  logic [ADDR_W-1:0]        umbral_bajo_in,
   input  logic [ADDR_W-1:0]        umbral_alto_in,
   input  logic [NUM_VC-1:0]        vc_empty,
   input  logic [NUM_VC*DATA_W-1:0] vc_data,
   input  logic [NUM_VC-1:0]        dst_almost_full,
   input  logic [NUM_VC-1:0]        dst_full,
   output logic [NUM_VC-1:0]        vc_pop,
   output logic [NUM_VC-1:0]        dst_push,
   output logic [DATA_W-1:0]        data_out,
   output logic [ADDR_W-1:0]        umbral_bajo,
   output logic [ADDR_W-1:0]        umbral_alto,
   output logic [2:0]               state,
   output logic                     idle,
   output logic                     error
);

   tl_state_e          state_q, state_d;
   logic [DATA_W-1:0]  word_p0 [NUM_VC];
   logic [1:0]         dest_p0 [NUM_VC];
   logic [NUM_VC-1:0]  eligible;
   logic [NUM_VC-1:0]  grant_oh;
   logic [1:0]         grant_idx;
   logic [1:0]         rr_ptr;
   logic               vld_p0;
   logic               overflow;
   logic [NUM_VC-1:0]  dst_push_p1;
   logic [DATA_W-1:0]  data_p1;

   // Stage p0: head-word decode, eligibility and grant
   always_comb begin
      word_p0  = '{default: '0};
      dest_p0  = '{default: '0};
      eligible = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         word_p0[i]  = vc_data[i*DATA_W +: DATA_W];
         dest_p0[i]  = dest_field(TL_DATA_W'(word_p0[i]), DEST_LSB);
         eligible[i] = !vc_empty[i] && !dst_almost_full[dest_p0[i]];
      end
   end

   tl_rr_pick u_pick (
      .eligible  (eligible),
      .ptr       (rr_ptr),
      .grant     (grant_oh),
      .grant_idx (grant_idx)
   );

   assign vld_p0   = (state_q == ST_ACTIVE) && (|eligible);
   assign vc_pop   = vld_p0 ? grant_oh : '0;
   assign overflow = |(dst_push_p1 & dst_full);

   always_comb begin
      state_d = state_q;
      if (state_q == ST_RESET) begin
         state_d = ST_INIT;
      end else if (init) begin
         state_d = ST_INIT;
      end else if (overflow) begin
         state_d = ST_ERROR;
      end else begin
         case (state_q)
            ST_INIT:   state_d = (umbral_bajo_in > umbral_alto_in) ? ST_ERROR : ST_IDLE;
            ST_IDLE:   if (!(&vc_empty)) state_d = ST_ACTIVE;
            ST_ACTIVE: if ((&vc_empty) && !vld_p0) state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state_q <= ST_RESET;
      else          state_q <= state_d;
   end

   // The last INIT cycle's inputs are the values that remain latched.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         umbral_bajo <= '0;
         umbral_alto <= '0;
      end else if (state_q == ST_INIT) begin
         umbral_bajo <= umbral_bajo_in;
         umbral_alto <= umbral_alto_in;
      end
   end

`ifdef TL_ARB_STRICT_PRIO_EN
   assign rr_ptr = '0;
`else
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)    rr_ptr <= '0;
      else if (vld_p0) rr_ptr <= grant_idx + 2'd1;
   end
`endif

   // Stage p1: registered push and word
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         dst_push_p1 <= '0;
         data_p1     <= '0;
      end else if (vld_p0) begin
         dst_push_p1 <= NUM_VC'(1) << dest_p0[grant_idx];
         data_p1     <= word_p0[grant_idx];
      end else begin
         dst_push_p1 <= '0;
      end
   end

   assign dst_push = dst_push_p1;
   assign data_out = data_p1;
   assign state    = state_q;
   assign idle     = (state_q == ST_IDLE);
   assign error    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_tl_vc_arbiter.sv
// Bench for tl_vc_arbiter: vector table, directed corner sequences and random
// traffic against a queue-based reference model.
module tb_tl_vc_arbiter;

   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          reset_L;
   logic          init;
   logic [2:0]    umbral_bajo_in, umbral_alto_in;
   logic [3:0]    vc_empty;
   logic [4*DW-1:0] vc_data;
   logic [3:0]    dst_almost_full, dst_full;
   logic [3:0]    vc_pop, dst_push;
   logic [DW-1:0] data_out;
   logic [2:0]    umbral_bajo, umbral_alto, state;
   logic          idle, error;

   tl_vc_arbiter dut (
      .clk             (clk),
      .reset_L         (reset_L),
      .init            (init),
      .umbral_bajo_in  (umbral_bajo_in),
      .umbral_alto_in  (umbral_alto_in),
      .vc_empty        (vc_empty),
      .vc_data         (vc_data),
      .dst_almost_full (dst_almost_full),
      .dst_full        (dst_full),
      .vc_pop          (vc_pop),
      .dst_push        (dst_push),
      .data_out        (data_out),
      .umbral_bajo     (umbral_bajo),
      .umbral_alto     (umbral_alto),
      .state           (state),
      .idle            (idle),
      .error           (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state (encoding: 0 RESET,1 INIT,2 IDLE,3 ACTIVE,4 ERROR)
   int            m_state, m_ptr, m_g;
   logic [2:0]    m_bajo, m_alto;
   logic [3:0]    m_push;
   logic [DW-1:0] m_data;
   logic [DW-1:0] vq [4][$];
   bit            use_q;

   logic [3:0] pop_seen, push_seen;
   logic [2:0] state_seen;
   logic [DW-1:0] data_seen;
   logic       error_seen;

   typedef struct {
      logic [3:0] empty;
      logic [7:0] dests;
      logic [3:0] af;
      logic [3:0] exp_rr;
      logic [3:0] exp_sp;
   } vec_t;
   vec_t tv [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dest_of(input int i);
      return int'(vc_data[i*DW + 8 +: 2]);
   endfunction

   function automatic int pick();
      for (int k = 0; k < 4; k++) begin
         int i;
`ifdef TL_ARB_STRICT_PRIO_EN
         i = k;
`else
         i = (m_ptr + k) % 4;
`endif
         if (!vc_empty[i] && !dst_almost_full[dest_of(i)]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_ptr = 0; m_g = -1;
      m_bajo = '0; m_alto = '0; m_push = '0; m_data = '0;
   endtask

   task automatic model_seq();
      int nxt;
      bit ovf;
      if (!reset_L) begin
         model_reset();
         return;
      end
      ovf = (m_push & dst_full) != 4'b0;
      if (m_state == 0)      nxt = 1;
      else if (init)         nxt = 1;
      else if (ovf)          nxt = 4;
      else begin
         case (m_state)
            1:       nxt = (umbral_bajo_in > umbral_alto_in) ? 4 : 2;
            2:       nxt = (vc_empty != 4'hF) ? 3 : 2;
            3:       nxt = (vc_empty == 4'hF && m_g < 0) ? 2 : 3;
            default: nxt = m_state;
         endcase
      end
      if (m_state == 1) begin
         m_bajo = umbral_bajo_in;
         m_alto = umbral_alto_in;
      end
      if (m_g >= 0) begin
         m_push = 4'(1 << dest_of(m_g));
         m_data = vc_data[m_g*DW +: DW];
         m_ptr  = (m_g + 1) % 4;
         if (use_q) void'(vq[m_g].pop_front());
      end else begin
         m_push = '0;
      end
      m_state = nxt;
   endtask

   task automatic drive_from_q();
      for (int i = 0; i < 4; i++) begin
         if (vq[i].size() == 0) begin
            vc_empty[i] = 1'b1;
            vc_data[i*DW +: DW] = '0;
         end else begin
            vc_empty[i] = 1'b0;
            vc_data[i*DW +: DW] = vq[i][0];
         end
      end
   endtask

   // One clock: drive at negedge, compare before the rising edge, advance model after it.
   task automatic tick();
      @(negedge clk);
      if (use_q) drive_from_q();
      #1;
      m_g = (m_state == 3) ? pick() : -1;
      pop_seen = vc_pop; push_seen = dst_push; data_seen = data_out;
      state_seen = state; error_seen = error;
      chk("vc_pop",   vc_pop,   (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
      chk("dst_push", dst_push, m_push);
      chk("data_out", data_out, m_data);
      chk("state",    state,    m_state);
      chk("idle",     idle,     m_state == 2);
      chk("error",    error,    m_state == 4);
      chk("bajo",     umbral_bajo, m_bajo);
      chk("alto",     umbral_alto, m_alto);
      @(posedge clk);
      #1;
      model_seq();
   endtask

   task automatic clear_q();
      for (int i = 0; i < 4; i++) vq[i].delete();
   endtask

   initial begin
      //             empty    dests  af       rr       strict
      tv[0]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0000, 4'b0000};
      tv[1]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0001, 4'b0001};
      tv[2]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0010, 4'b0001};
      tv[3]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0100, 4'b0001};
      tv[4]  = '{4'b0000, 8'hE4, 4'b0000, 4'b1000, 4'b0001};
      tv[5]  = '{4'b0000, 8'hE4, 4'b0000, 4'b0001, 4'b0001};
      tv[6]  = '{4'b0000, 8'h9C, 4'b0010, 4'b0010, 4'b0001};
      tv[7]  = '{4'b0000, 8'h9C, 4'b0010, 4'b1000, 4'b0001};
      tv[8]  = '{4'b0000, 8'h9C, 4'b0010, 4'b0001, 4'b0001};
      tv[9]  = '{4'b0001, 8'h9C, 4'b0010, 4'b0010, 4'b0010};
      tv[10] = '{4'b0001, 8'h9C, 4'b0010, 4'b1000, 4'b0010};
      tv[11] = '{4'b0001, 8'h9C, 4'b0000, 4'b0010, 4'b0010};
      tv[12] = '{4'b0001, 8'h9C, 4'b0000, 4'b0100, 4'b0010};
      tv[13] = '{4'b0000, 8'h00, 4'b0001, 4'b0000, 4'b0000};
      tv[14] = '{4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0000};
      tv[15] = '{4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0000};

      reset_L = 1'b0; init = 1'b0;
      umbral_bajo_in = 3'd1; umbral_alto_in = 3'd7;
      vc_empty = 4'hF; vc_data = '0; dst_almost_full = '0; dst_full = '0;
      use_q = 1'b1;
      model_reset();
      clear_q();

      // Reset, then init pulse with thresholds 1/7
      tick();
      tick();
      reset_L = 1'b1;
      tick();
      chk("rst_state", state_seen, 0);
      tick();
      chk("init_after_rst", state_seen, 1);
      tick();
      init = 1'b1;
      tick();
      init = 1'b0;
      tick();
      chk("init_state", state_seen, 1);
      tick();
      chk("idle_after_init", state_seen, 2);
      chk("bajo_latched", umbral_bajo, 3'd1);
      chk("alto_latched", umbral_alto, 3'd7);

      // Vector table, driven directly
      use_q = 1'b0;
      for (int e = 0; e < 16; e++) begin
         vc_empty = tv[e].empty;
         dst_almost_full = tv[e].af;
         for (int i = 0; i < 4; i++)
            vc_data[i*DW +: DW] = {2'(i), tv[e].dests[2*i +: 2], 4'(e), 4'(i)};
         tick();
`ifdef TL_ARB_STRICT_PRIO_EN
         chk($sformatf("tbl_pop[%0d]", e), pop_seen, tv[e].exp_sp);
`else
         chk($sformatf("tbl_pop[%0d]", e), pop_seen, tv[e].exp_rr);
`endif
      end

      // Single word: payload 15 with destination 2 gives head word 0x20F
      use_q = 1'b1;
      dst_almost_full = '0;
      clear_q();
      vq[0].push_back(12'h20F);
      tick();
      tick();
      chk("single_pop", pop_seen, 4'b0001);
      tick();
      chk("single_push", push_seen, 4'b0100);
      chk("single_data", data_seen, 12'h20F);
      tick();
      chk("single_idle", state_seen, 2);
      chk("single_drain", push_seen, 4'b0000);

      // Overflow on destination 3
      vq[1].push_back(12'h355);
      tick();
      tick();
      chk("ovf_pop", pop_seen, 4'b0010);
      dst_full = 4'b1000;
      tick();
      chk("ovf_push", push_seen, 4'b1000);
      dst_full = 4'b0000;
      vq[0].push_back(12'h011);
      tick();
      chk("ovf_state", state_seen, 4);
      chk("ovf_error", error_seen, 1'b1);
      chk("ovf_nopop", pop_seen, 4'b0000);
      tick();
      chk("err_nopop", pop_seen, 4'b0000);
      init = 1'b1;
      tick();
      init = 1'b0;
      tick();
      chk("err_clr_state", state_seen, 1);
      chk("err_clr_flag", error_seen, 1'b0);
      repeat (5) tick();

      // Bad configuration: low above high
      umbral_bajo_in = 3'd5; umbral_alto_in = 3'd3;
      init = 1'b1;
      tick();
      init = 1'b0;
      tick();
      chk("badcfg_init", state_seen, 1);
      tick();
      chk("badcfg_state", state_seen, 4);
      chk("badcfg_error", error_seen, 1'b1);
      chk("badcfg_bajo", umbral_bajo, 3'd5);
      umbral_bajo_in = 3'd1; umbral_alto_in = 3'd7;
      init = 1'b1;
      tick();
      init = 1'b0;
      repeat (2) tick();

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < 4; i++)
            if (vq[i].size() < 8 && $urandom_range(0, 2) == 0) vq[i].push_back(12'($urandom));
         dst_almost_full = 4'($urandom & $urandom);
         dst_full = ($urandom_range(0, 63) == 0) ? 4'($urandom) : 4'b0;
         init = (m_state == 4) || ($urandom_range(0, 199) == 0);
         if (init) begin
            umbral_alto_in = 3'($urandom_range(3, 7));
            umbral_bajo_in = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
         end
         tick();
      end

      // Asynchronous reset while a push is pending
      init = 1'b1; dst_full = '0; dst_almost_full = '0;
      umbral_bajo_in = 3'd1; umbral_alto_in = 3'd7;
      tick();
      init = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vq[i].push_back(12'h0A0 + 12'(i));
         vq[i].push_back(12'h1B0 + 12'(i));
      end
      for (int n = 0; n < 20 && !(m_state == 3 && m_push != 4'b0); n++) tick();
      chk("pending_push", dst_push != 4'b0, 1);
      #1;
      reset_L = 1'b0;
      #1;
      chk("arst_pop",   vc_pop, 0);
      chk("arst_push",  dst_push, 0);
      chk("arst_data",  data_out, 0);
      chk("arst_state", state, 0);
      chk("arst_bajo",  umbral_bajo, 0);
      chk("arst_alto",  umbral_alto, 0);
      chk("arst_flags", {idle, error}, 0);
      model_reset();
      clear_q();
      tick();
      reset_L = 1'b1;
      tick();
      tick();
      chk("post_rst_init", state_seen, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl_vc_arbiter.md
Name: tl_vc_arbiter

Overview:
Main control block of the transaction-layer datapath. It sequences the layer through reset, init, idle and active states, and latches the FIFO low/high thresholds during init. It then arbitrates four input VC FIFOs (P0..P3) onto four destination FIFOs, routing each 12-bit word by its destination field. Flow control comes from the destination almost-full flags, so no destination FIFO overflows.

Parameters:
DATA_W, 12, word width
ADDR_W, 3, threshold width; matches FIFO depth 8
DEST_LSB, 8, LSB of the 2-bit destination field in each word

Ports:
clk  in  1  rising-edge clock
reset_L  in  1  asynchronous, active-low reset
init  in  1  one-cycle pulse; enter INIT and latch thresholds
umbral_bajo_in  in  ADDR_W  low threshold to latch
umbral_alto_in  in  ADDR_W  high threshold to latch
vc_empty  in  4  empty flags of input FIFOs P0..P3
vc_data  in  4*DATA_W  show-ahead head words; P0 in bits [DATA_W-1:0]
dst_almost_full  in  4  destination almost-full flags (occupancy >= umbral_alto)
dst_full  in  4  destination full flags
vc_pop  out  4  one-hot pop, combinational, same cycle as grant
dst_push  out  4  one-hot push, registered
data_out  out  DATA_W  registered word, valid when dst_push != 0
umbral_bajo  out  ADDR_W  latched threshold driven to all FIFOs
umbral_alto  out  ADDR_W  latched threshold driven to all FIFOs
state  out  3  current FSM state
idle  out  1  high in IDLE
error  out  1  sticky error flag

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=RESET; all outputs 0; round-robin pointer=0; thresholds 0.
  - FSM goes RESET->INIT on the first clock after reset_L deasserts.
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- INIT:
  - Every cycle in INIT loads umbral_bajo/umbral_alto from the *_in ports.
  - Stays in INIT while init=1; goes to IDLE on the first cycle with init=0.
- An init pulse in any non-RESET state returns to INIT. Any pending push still completes.
- IDLE:
  - Goes to ACTIVE when any vc_empty bit is 0.
  - Makes no grant in the cycle it leaves IDLE.
- ACTIVE:
  - Goes to IDLE when all vc_empty=1 and no push is registered for the next cycle.
- Eligibility: requester i is eligible iff vc_empty[i]=0 and dst_almost_full[d_i]=0, where d_i = vc_data word i bits [DEST_LSB+1:DEST_LSB].
- Grant, at most one per cycle in ACTIVE:
  - The first eligible requester at or after rr_ptr, searching 0..3 and wrapping, is granted.
  - vc_pop[g]=1 combinationally.
  - On the next edge: dst_push <= one-hot(d_g), data_out <= word g, rr_ptr <= g+1 mod 4.
- Latency: one cycle from pop to push. Throughput: one word per cycle.
- No eligible requester: vc_pop=0, dst_push<=0, data_out holds its value, rr_ptr unchanged.
- The almost-full margin (umbral_alto < depth) absorbs the one in-flight push. Almost-full is checked only at grant time.
- Error:
  - Detected when dst_push[k]=1 while dst_full[k]=1, or when umbral_bajo > umbral_alto on leaving INIT.
  - Either condition drives ERROR; error=1.
  - ERROR leaves only on reset or init; init clears error.
  - No pops occur in ERROR.
- vc_pop is never asserted outside ACTIVE. dst_push drains its final registered value in the first cycle after leaving ACTIVE.

Optional Feature:
- Macro TL_ARB_STRICT_PRIO_EN.
- Defined: strict priority with P0 highest; rr_ptr is not implemented; the lowest-index eligible requester always wins.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Decomposition:
- Package tl_pkg holds:
  - state enum/localparams (RESET..ERROR)
  - NUM_VC=4
  - dest-field extraction helper
  - DATA_W/ADDR_W defaults, shared with the FIFO and demux blocks.
- One natural sub-module: tl_rr_pick, a combinational 4-way priority/round-robin picker. Inputs: eligible vector and pointer. Outputs: one-hot grant and index. The macro selects the variant inside it.

Test Plan:
- Reset/init: reset_L low mid-ACTIVE with push pending -> all outputs 0 immediately. Release, pulse init with thresholds 1/7 -> state INIT->IDLE, umbral_bajo=1, umbral_alto=7.
- Single word: P0 holds 15 with dest 2 -> vc_pop=0001 one cycle; next cycle dst_push=0100, data_out=15. Returns to IDLE after drain.
- Fairness: all four VCs non-empty, dests distinct, nothing almost-full -> grants P0,P1,P2,P3,P0.... With TL_ARB_STRICT_PRIO_EN -> P0 on every cycle until P0 is empty.
- Backpressure: dst_almost_full[1]=1 and P2 head dest 1 -> P2 is never popped while other VCs proceed. Drop the flag -> P2 is granted within 4 cycles.
- Overflow error: force dst_full[3]=1 in the cycle dst_push=1000 -> state ERROR, error=1, no pops. An init pulse -> error=0, state INIT.
- Bad config: init with bajo=5, alto=3 -> ERROR on the INIT exit cycle.
